// File: rtl/cu_pkg.sv
// Shared types and constants for the lockstep multicore control unit:
// state encodings, opcodes, control-word bit positions and the control-word struct.
package cu_pkg;

  typedef logic [4:0] state_t;

  localparam state_t FETCH1 = 5'd0;
  localparam state_t FETCH2 = 5'd1;
  localparam state_t FETCH3 = 5'd2;
  localparam state_t DECODE = 5'd3;
  localparam state_t STAC1  = 5'd4;
  localparam state_t STAC2  = 5'd5;
  localparam state_t LDAC1  = 5'd6;
  localparam state_t LDAC2  = 5'd7;
  localparam state_t LDAC3  = 5'd8;
  localparam state_t ST1    = 5'd9;
  localparam state_t ST2    = 5'd10;
  localparam state_t ST3    = 5'd11;
  localparam state_t LD1    = 5'd12;
  localparam state_t LD2    = 5'd13;
  localparam state_t LD3    = 5'd14;
  localparam state_t MVAT1  = 5'd15;
  localparam state_t MVT1   = 5'd16;
  localparam state_t MVAR1  = 5'd17;
  localparam state_t MVR1   = 5'd18;
  localparam state_t CLAC1  = 5'd19;
  localparam state_t ADD1   = 5'd20;
  localparam state_t SUB1   = 5'd21;
  localparam state_t MULT1  = 5'd22;
  localparam state_t INC1   = 5'd23;
  localparam state_t JPNZ1  = 5'd24;
  localparam state_t NOP1   = 5'd25;
  localparam state_t END1   = 5'd26;

  localparam logic [3:0] OP_STAC = 4'd0;
  localparam logic [3:0] OP_LDAC = 4'd1;
  localparam logic [3:0] OP_ST   = 4'd2;
  localparam logic [3:0] OP_LD   = 4'd3;
  localparam logic [3:0] OP_MVAT = 4'd4;
  localparam logic [3:0] OP_MVT  = 4'd5;
  localparam logic [3:0] OP_MVAR = 4'd6;
  localparam logic [3:0] OP_MVR  = 4'd7;
  localparam logic [3:0] OP_CLAC = 4'd8;
  localparam logic [3:0] OP_ADD  = 4'd9;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_MULT = 4'd11;
  localparam logic [3:0] OP_INC  = 4'd12;
  localparam logic [3:0] OP_JPNZ = 4'd13;
  localparam logic [3:0] OP_NOP  = 4'd14;
  localparam logic [3:0] OP_END  = 4'd15;

  // REGld = {Memoryin,ARld,PCld,DRld,IRld,TRld,Rld,ACld}
  localparam int RL_AC    = 0;
  localparam int RL_R     = 1;
  localparam int RL_TR    = 2;
  localparam int RL_IR    = 3;
  localparam int RL_DR    = 4;
  localparam int RL_PC    = 5;
  localparam int RL_AR    = 6;
  localparam int RL_MEMIN = 7;

  // BUSld = {Memoryout,PCbus,DRbus,TRbus,Rbus,ACbus}
  localparam int BL_AC  = 0;
  localparam int BL_R   = 1;
  localparam int BL_TR  = 2;
  localparam int BL_DR  = 3;
  localparam int BL_PC  = 4;
  localparam int BL_MEM = 5;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_MULT = 2'd2;
  localparam logic [1:0] ALU_INC  = 2'd3;

  typedef struct packed {
    logic       acselector;
    logic [1:0] aluop;
    logic [7:0] regld;
    logic [5:0] busld;
    logic       memwrite;
    logic [1:0] regreset;
    logic       reginc;
  } ctrl_word_t;

  localparam ctrl_word_t RESET_WORD = '{acselector: 1'b0, aluop: 2'd0, regld: 8'd0,
                                        busld: 6'd0, memwrite: 1'b0, regreset: 2'b11,
                                        reginc: 1'b0};

  function automatic state_t decode_op(input logic [3:0] op);
    case (op)
      OP_STAC: return STAC1;
      OP_LDAC: return LDAC1;
      OP_ST:   return ST1;
      OP_LD:   return LD1;
      OP_MVAT: return MVAT1;
      OP_MVT:  return MVT1;
      OP_MVAR: return MVAR1;
      OP_MVR:  return MVR1;
      OP_CLAC: return CLAC1;
      OP_ADD:  return ADD1;
      OP_SUB:  return SUB1;
      OP_MULT: return MULT1;
      OP_INC:  return INC1;
      OP_JPNZ: return JPNZ1;
      OP_NOP:  return NOP1;
      default: return END1;
    endcase
  endfunction

endpackage

// File: rtl/cu_multicore_seq_if.sv
// Control-unit bundle: opcode/flag/memory inputs, broadcast control word and status.
// instr_count exists only when CU_PERF_CNT_EN is defined.
interface cu_multicore_seq_if #(
  parameter int NUM_CORES = 3,
  parameter int CNT_W     = 16
);
  import cu_pkg::*;

  logic [3:0]           ins;
  logic [NUM_CORES-1:0] z;
  // mem_req is the valid side: it stays high, with mem_we and the address/data
  // bus selection stable, until a cycle in which mem_ready is sampled high; that
  // edge completes the access and mem_req drops for the commit cycle.
  logic                 mem_ready;
  logic                 ACselector;
  logic [1:0]           ALUop;
  logic [7:0]           REGld;
  logic [5:0]           BUSld;
  logic                 MemWrite;
  logic [1:0]           REGreset;
  logic                 REGinc;
  logic                 mem_req;
  logic                 mem_we;
  logic                 halted;
  state_t               dbg_state;
`ifdef CU_PERF_CNT_EN
  logic [CNT_W-1:0]     instr_count;
`endif

  modport master (
    input  ins, z, mem_ready,
    output ACselector, ALUop, REGld, BUSld, MemWrite, REGreset, REGinc,
    output mem_req, mem_we, halted, dbg_state
`ifdef CU_PERF_CNT_EN
    , output instr_count
`endif
  );

  modport slave (
    output ins, z, mem_ready,
    input  ACselector, ALUop, REGld, BUSld, MemWrite, REGreset, REGinc,
    input  mem_req, mem_we, halted, dbg_state
`ifdef CU_PERF_CNT_EN
    , input instr_count
`endif
  );

endinterface

// File: rtl/cu_ctrl_rom.sv
// Combinational state-to-control-word table, plus flags marking memory steps.
module cu_ctrl_rom
  import cu_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t word,
  output logic       is_mem,
  output logic       mem_wr
);

  always_comb begin
    word   = '0;
    is_mem = 1'b0;
    mem_wr = 1'b0;
    case (state)
      FETCH1: begin word.regld[RL_AR] = 1'b1; word.busld[BL_PC] = 1'b1; end
      FETCH2: begin
        word.regld[RL_DR] = 1'b1; word.busld[BL_MEM] = 1'b1; word.reginc = 1'b1;
        is_mem = 1'b1;
      end
      FETCH3: begin word.regld[RL_IR] = 1'b1; word.busld[BL_DR] = 1'b1; end
      STAC1, LDAC1, ST1, LD1: begin word.regld[RL_AR] = 1'b1; word.busld[BL_DR] = 1'b1; end
      STAC2: begin
        word.regld[RL_MEMIN] = 1'b1; word.busld[BL_AC] = 1'b1; word.memwrite = 1'b1;
        is_mem = 1'b1; mem_wr = 1'b1;
      end
      LDAC2, LD2: begin
        word.regld[RL_DR] = 1'b1; word.busld[BL_MEM] = 1'b1; is_mem = 1'b1;
      end
      LDAC3: begin word.regld[RL_AC] = 1'b1; word.busld[BL_DR] = 1'b1; end
      ST2: begin word.regld[RL_DR] = 1'b1; word.busld[BL_AC] = 1'b1; end
      ST3: begin
        word.regld[RL_MEMIN] = 1'b1; word.busld[BL_DR] = 1'b1; word.memwrite = 1'b1;
        is_mem = 1'b1; mem_wr = 1'b1;
      end
      LD3:   begin word.regld[RL_R]  = 1'b1; word.busld[BL_DR] = 1'b1; end
      MVAT1: begin word.regld[RL_TR] = 1'b1; word.busld[BL_AC] = 1'b1; end
      MVT1:  begin word.regld[RL_AC] = 1'b1; word.busld[BL_TR] = 1'b1; end
      MVAR1: begin word.regld[RL_R]  = 1'b1; word.busld[BL_AC] = 1'b1; end
      MVR1:  begin word.regld[RL_AC] = 1'b1; word.busld[BL_R]  = 1'b1; end
      CLAC1: word.regreset = 2'b10;
      ADD1, SUB1, MULT1: begin
        word.regld[RL_AC] = 1'b1; word.busld[BL_R] = 1'b1; word.acselector = 1'b1;
        word.aluop = (state == ADD1) ? ALU_ADD : (state == SUB1) ? ALU_SUB : ALU_MULT;
      end
      INC1: begin word.regld[RL_AC] = 1'b1; word.acselector = 1'b1; word.aluop = ALU_INC; end
      // JPNZ1 carries the taken word; the sequencer blanks it when not taken.
      JPNZ1: begin word.regld[RL_PC] = 1'b1; word.busld[BL_DR] = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/cu_multicore_seq.sv
// Lockstep microcoded sequencer: registered control word, memory WAIT/COMMIT
// handshake, JPNZ zero-flag combine. Optional CU_PERF_CNT_EN adds instr_count.
module cu_multicore_seq
  import cu_pkg::*;
#(
  parameter int NUM_CORES     = 3,
  parameter int JPNZ_MODE     = 0,
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 16
) (
  input logic                clk,
  input logic                resetCU,
  cu_multicore_seq_if.master bus
);

  state_t               state, state_nxt;
  logic                 waiting, waiting_nxt, hold;
  logic                 is_mem, mem_wr, jump;
  logic                 req_nxt, we_nxt;
  logic                 mem_req_q, mem_we_q, halted_q;
  logic [NUM_CORES-1:0] z_s;
  ctrl_word_t           rom_word, word_nxt, word_q;

  cu_ctrl_rom u_rom (
    .state  (state),
    .word   (rom_word),
    .is_mem (is_mem),
    .mem_wr (mem_wr)
  );

  assign z_s  = bus.z;
  assign jump = (JPNZ_MODE == 0) ? ~(&z_s) : ~(|z_s);

  always_comb begin
    state_nxt = FETCH1;
    case (state)
      FETCH1:  state_nxt = FETCH2;
      FETCH2:  state_nxt = FETCH3;
      FETCH3:  state_nxt = DECODE;
      DECODE:  state_nxt = decode_op(bus.ins);
      STAC1:   state_nxt = STAC2;
      LDAC1:   state_nxt = LDAC2;
      LDAC2:   state_nxt = LDAC3;
      ST1:     state_nxt = ST2;
      ST2:     state_nxt = ST3;
      LD1:     state_nxt = LD2;
      LD2:     state_nxt = LD3;
      END1:    state_nxt = END1;
      default: state_nxt = FETCH1;
    endcase
  end

  // A memory step shows its bus selection with mem_req until mem_ready is seen
  // while waiting; only then does the full word go out once and the state move on.
  always_comb begin
    word_nxt    = rom_word;
    req_nxt     = 1'b0;
    we_nxt      = 1'b0;
    waiting_nxt = 1'b0;
    hold        = 1'b0;
    if ((MEM_HANDSHAKE != 0) && is_mem && !(waiting && bus.mem_ready)) begin
      word_nxt       = '0;
      word_nxt.busld = rom_word.busld;
      req_nxt        = 1'b1;
      we_nxt         = mem_wr;
      waiting_nxt    = 1'b1;
      hold           = 1'b1;
    end
    if ((state == JPNZ1) && !jump) word_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (resetCU) begin
      state     <= FETCH1;
      waiting   <= 1'b0;
      word_q    <= RESET_WORD;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state     <= hold ? state : state_nxt;
      waiting   <= waiting_nxt;
      word_q    <= word_nxt;
      mem_req_q <= req_nxt;
      mem_we_q  <= we_nxt;
      if (state == END1) halted_q <= 1'b1;
    end
  end

`ifdef CU_PERF_CNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (resetCU)              count_q <= '0;
    else if (state == DECODE) count_q <= count_q + CNT_W'(1);
  end

  assign bus.instr_count = count_q;
`endif

  assign bus.ACselector = word_q.acselector;
  assign bus.ALUop      = word_q.aluop;
  assign bus.REGld      = word_q.regld;
  assign bus.BUSld      = word_q.busld;
  assign bus.MemWrite   = word_q.memwrite;
  assign bus.REGreset   = word_q.regreset;
  assign bus.REGinc     = word_q.reginc;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.halted     = halted_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_cu_multicore_seq.sv
// Directed bench: three CUs (JPNZ any-zero / all-zero with handshake, and a
// no-handshake legacy-timing instance) driven from shared opcode, flags and ready.
module tb_cu_multicore_seq;
  import cu_pkg::*;

  logic       clk = 1'b0;
  logic       resetCU;
  logic [3:0] ins;
  logic [2:0] z;
  logic       mem_ready;

  int n_vec = 0;
  int n_err = 0;
  logic [20:0] exp_q[$];

  int cnt_req, cnt_we, cnt_we_noreq, cnt_mw, cnt_mw_req, cnt_acld, cnt_pcld_a, cnt_pcld_b;

  always #5 clk = ~clk;

  cu_multicore_seq_if #(.NUM_CORES(3), .CNT_W(16)) a_if ();
  cu_multicore_seq_if #(.NUM_CORES(3), .CNT_W(16)) b_if ();
  cu_multicore_seq_if #(.NUM_CORES(3), .CNT_W(16)) c_if ();

  assign a_if.ins = ins;  assign a_if.z = z;  assign a_if.mem_ready = mem_ready;
  assign b_if.ins = ins;  assign b_if.z = z;  assign b_if.mem_ready = mem_ready;
  assign c_if.ins = ins;  assign c_if.z = z;  assign c_if.mem_ready = mem_ready;

  cu_multicore_seq #(.NUM_CORES(3), .JPNZ_MODE(0), .MEM_HANDSHAKE(1), .CNT_W(16)) dut_a (
    .clk(clk), .resetCU(resetCU), .bus(a_if));
  cu_multicore_seq #(.NUM_CORES(3), .JPNZ_MODE(1), .MEM_HANDSHAKE(1), .CNT_W(16)) dut_b (
    .clk(clk), .resetCU(resetCU), .bus(b_if));
  cu_multicore_seq #(.NUM_CORES(3), .JPNZ_MODE(0), .MEM_HANDSHAKE(0), .CNT_W(16)) dut_c (
    .clk(clk), .resetCU(resetCU), .bus(c_if));

  logic [20:0] obs_a, obs_c;
  assign obs_a = {a_if.ACselector, a_if.ALUop, a_if.REGld, a_if.BUSld,
                  a_if.MemWrite, a_if.REGreset, a_if.REGinc};
  assign obs_c = {c_if.ACselector, c_if.ALUop, c_if.REGld, c_if.BUSld,
                  c_if.MemWrite, c_if.REGreset, c_if.REGinc};

  function automatic logic [20:0] mk(input logic acs, input logic [1:0] op,
                                     input logic [7:0] rl, input logic [5:0] bl,
                                     input logic mw, input logic [1:0] rr, input logic inc);
    return {acs, op, rl, bl, mw, rr, inc};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetCU = 1'b1;
    tick();
    tick();
    resetCU = 1'b0;
  endtask

  // FETCH1, FETCH2 wait, FETCH2 commit, FETCH3, DECODE with ready already high.
  task automatic to_decode();
    mem_ready = 1'b1;
    repeat (5) tick();
  endtask

  task automatic clear_counts();
    cnt_req = 0; cnt_we = 0; cnt_we_noreq = 0; cnt_mw = 0; cnt_mw_req = 0;
    cnt_acld = 0; cnt_pcld_a = 0; cnt_pcld_b = 0;
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      tick();
      cnt_req      += int'(a_if.mem_req);
      cnt_we       += int'(a_if.mem_we);
      cnt_we_noreq += int'(a_if.mem_we & ~a_if.mem_req);
      cnt_mw       += int'(a_if.MemWrite);
      cnt_mw_req   += int'(a_if.MemWrite & a_if.mem_req);
      cnt_acld     += int'(a_if.REGld[RL_AC]);
      cnt_pcld_a   += int'(a_if.REGld[RL_PC]);
      cnt_pcld_b   += int'(b_if.REGld[RL_PC]);
    end
  endtask

  initial begin
    logic [2:0] zv [3];
    int         exp_pa [3];
    int         exp_pb [3];
    int         bad;
    zv = '{3'b011, 3'b000, 3'b111};
    exp_pa = '{1, 1, 0};
    exp_pb = '{0, 1, 0};

    resetCU = 1'b1; ins = OP_STAC; z = 3'b000; mem_ready = 1'b1;

    // Reset state and the first fetch with the handshake instance.
    do_reset();
    check("rst_regreset", 32'(a_if.REGreset), 32'h3);
    check("rst_regld",    32'(a_if.REGld),    32'h0);
    check("rst_memreq",   32'(a_if.mem_req),  32'h0);
    check("rst_halted",   32'(a_if.halted),   32'h0);
    check("rst_c_word",   32'(obs_c),         32'(mk(1'b0, 2'd0, 8'h00, 6'h00, 1'b0, 2'b11, 1'b0)));
`ifdef CU_PERF_CNT_EN
    check("rst_cnt",      32'(a_if.instr_count), 32'h0);
`endif
    tick();
    check("f1_regld",     32'(a_if.REGld),    32'h40);
    check("f1_busld",     32'(a_if.BUSld),    32'h10);
    tick();
    check("f2w_memreq",   32'(a_if.mem_req),  32'h1);
    check("f2w_regld",    32'(a_if.REGld),    32'h0);
    check("f2w_busld",    32'(a_if.BUSld),    32'h20);
    check("f2w_reginc",   32'(a_if.REGinc),   32'h0);
    tick();
    check("f2c_reginc",   32'(a_if.REGinc),   32'h1);
    check("f2c_regld",    32'(a_if.REGld),    32'h10);
    check("f2c_memreq",   32'(a_if.mem_req),  32'h0);
    tick();
    check("f3_regld",     32'(a_if.REGld),    32'h08);
    tick();
    check("dec_word",     32'(obs_a),         32'h0);

    // STAC: ready low on the first two waiting edges, so WAIT lasts three cycles.
    clear_counts();
    mem_ready = 1'b0;
    watch(4);
    mem_ready = 1'b1;
    watch(2);
    check("stac_req_cycles",  32'(cnt_req),      32'd3);
    check("stac_we_cycles",   32'(cnt_we),       32'd3);
    check("stac_we_noreq",    32'(cnt_we_noreq), 32'd0);
    check("stac_memwrite",    32'(cnt_mw),       32'd1);
    check("stac_mw_in_wait",  32'(cnt_mw_req),   32'd0);
    check("stac_back_fetch",  32'(a_if.REGld),   32'h40);

    // LDAC: ready low for four WAIT cycles, then the DR commit and the AC load.
    ins = OP_LDAC;
    do_reset();
    to_decode();
    clear_counts();
    mem_ready = 1'b0;
    watch(5);
    mem_ready = 1'b1;
    watch(1);
    check("ldac_commit_regld", 32'(a_if.REGld),      32'h10);
    check("ldac_commit_req",   32'(a_if.mem_req),    32'h0);
    watch(1);
    check("ldac3_regld",       32'(a_if.REGld),      32'h01);
    check("ldac3_busld",       32'(a_if.BUSld),      32'h08);
    check("ldac3_acsel",       32'(a_if.ACselector), 32'h0);
    watch(1);
    check("ldac_req_cycles",   32'(cnt_req),         32'd4);
    check("ldac_we_cycles",    32'(cnt_we),          32'd0);
    check("ldac_acld_pulses",  32'(cnt_acld),        32'd1);

    // JPNZ with both combine modes side by side.
    ins = OP_JPNZ;
    for (int i = 0; i < 3; i++) begin
      z = zv[i];
      do_reset();
      to_decode();
      clear_counts();
      watch(2);
      check($sformatf("jpnz_any_z%b", zv[i]), 32'(cnt_pcld_a), 32'(exp_pa[i]));
      check($sformatf("jpnz_all_z%b", zv[i]), 32'(cnt_pcld_b), 32'(exp_pb[i]));
    end
    z = 3'b000;

    // END: halt holds across opcode changes until reset.
    ins = OP_END;
    do_reset();
    to_decode();
    tick();
    check("end_halted", 32'(a_if.halted), 32'h1);
    check("end_word",   32'(obs_a),       32'h0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      ins = 4'($urandom_range(0, 15));
      mem_ready = 1'($urandom_range(0, 1));
      tick();
      if (a_if.halted !== 1'b1 || obs_a !== 21'h0 || a_if.mem_req !== 1'b0) bad++;
    end
    check("halt_hold_bad_cycles", 32'(bad), 32'd0);
`ifdef CU_PERF_CNT_EN
    check("halt_cnt", 32'(a_if.instr_count), 32'd1);
`endif
    resetCU = 1'b1;
    tick();
    check("unhalt_halted",   32'(a_if.halted),   32'h0);
    check("unhalt_regreset", 32'(a_if.REGreset), 32'h3);
    resetCU = 1'b0;

    // Legacy timing: ADD is five cycles, no memory handshake outputs.
    ins = OP_ADD;
    mem_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk(1'b0, 2'd0, 8'h40, 6'h10, 1'b0, 2'b00, 1'b0));
      exp_q.push_back(mk(1'b0, 2'd0, 8'h10, 6'h20, 1'b0, 2'b00, 1'b1));
      exp_q.push_back(mk(1'b0, 2'd0, 8'h08, 6'h08, 1'b0, 2'b00, 1'b0));
      exp_q.push_back(mk(1'b0, 2'd0, 8'h00, 6'h00, 1'b0, 2'b00, 1'b0));
      exp_q.push_back(mk(1'b1, ALU_ADD, 8'h01, 6'h02, 1'b0, 2'b00, 1'b0));
    end
    for (int k = 0; k < 15; k++) begin
      logic [20:0] exp_w;
      tick();
      exp_w = exp_q.pop_front();
      check($sformatf("legacy_add_c%0d", k), 32'(obs_c), 32'(exp_w));
      check($sformatf("legacy_req_c%0d", k), 32'({c_if.mem_req, c_if.mem_we}), 32'h0);
    end
`ifdef CU_PERF_CNT_EN
    check("legacy_cnt", 32'(c_if.instr_count), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
